// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg
// Shared definitions for the data-side memory bridge: FSM state encoding,
// load/store width encodings (shared with the pipeline controller), default
// UART register addresses and small store-lane helper functions.
package mem_bridge_pkg;

    // Bridge transaction states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD1   = 3'd1,
        ST_RD2   = 3'd2,
        ST_WR1   = 3'd3,
        ST_WR2   = 3'd4,
        ST_UWAIT = 3'd5,
        ST_DONE  = 3'd6
    } bridgeState_e;

    // Load width select (mem_rsel)
    localparam logic [1:0] RSEL_WORD  = 2'b00;
    localparam logic [1:0] RSEL_SBYTE = 2'b01;
    localparam logic [1:0] RSEL_UBYTE = 2'b10;
    localparam logic [1:0] RSEL_SHALF = 2'b11;

    // Store width select (mem_wsel)
    localparam logic WSEL_WORD = 1'b0;
    localparam logic WSEL_BYTE = 1'b1;

    // Memory-mapped UART registers
    localparam logic [31:0] DEF_UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] DEF_UART_STAT_ADDR = 32'hBFD0_03FC;

    // Active-low byte enables for a store: a byte store opens only its lane
    function automatic logic [3:0] storeByteEnN(input logic wsel, input logic [1:0] lane);
        logic [3:0] enN;
        if (wsel == WSEL_BYTE) begin
            enN = ~(4'b0001 << lane);
        end else begin
            enN = 4'b0000;
        end
        return enN;
    endfunction

    // Store data as driven on the SRAM bus: a byte store is replicated to all lanes
    function automatic logic [31:0] storeData(input logic wsel, input logic [31:0] wdata);
        logic [31:0] dout;
        if (wsel == WSEL_BYTE) begin
            dout = {4{wdata[7:0]}};
        end else begin
            dout = wdata;
        end
        return dout;
    endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// mem_bridge_if
// CPU MEM-stage request bus towards the memory bridge.
//   master : CPU side   (drives address/data/enables/widths, receives rdata/busy/done)
//   slave  : bridge side
interface mem_bridge_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_rsel;
    logic        mem_wsel;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we, mem_rsel, mem_wsel,
        input  mem_rdata, busy, done
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we, mem_rsel, mem_wsel,
        output mem_rdata, busy, done
    );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align
// Combinational load extraction: picks the byte/half addressed by addrLow out
// of a 32-bit word and sign- or zero-extends it according to rsel.
//   word    in  32 : word read from memory
//   addrLow in  2  : byte address bits [1:0]
//   rsel    in  2  : load width/extension select
//   result  out 32 : aligned, extended load value
module mem_load_align
    import mem_bridge_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addrLow,
    input  logic [1:0]  rsel,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection; addrLow[0] is irrelevant for halfwords
    always_comb begin
        byte_s = 8'd0;
        case (addrLow)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'd0;
        endcase
        if (addrLow[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extension according to the requested load width
    always_comb begin
        result = 32'd0;
        case (rsel)
            RSEL_WORD:  result = word;
            RSEL_SBYTE: result = {{24{byte_s[7]}}, byte_s};
            RSEL_UBYTE: result = {24'd0, byte_s};
            RSEL_SHALF: result = {{16{half_s[15]}}, half_s};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge
// Runs CPU MEM-stage loads/stores as multi-cycle transactions to an external
// asynchronous 32-bit SRAM or to the memory-mapped UART registers, stalling
// the pipeline through busy until the one-cycle done pulse.
//   clk, rst            : clock, synchronous active-high reset
//   cpu (slave)         : request bus (addr, wdata, re, we, rsel, wsel / rdata, busy, done)
//   sram_*              : word address, write data, read data, tristate enable,
//                         active-low chip/output/write enables and byte enables
//   uart_*              : transmitter idle/start/data, receiver avail/data/ack
// The bridge drives no tristate itself; sram_dout/sram_doe are combined at
// the board top level.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE       = 32'h8000_0000,
    parameter int          SRAM_WORDS_LOG2 = 21,
    parameter logic [31:0] UART_DATA_ADDR  = DEF_UART_DATA_ADDR,
    parameter logic [31:0] UART_STAT_ADDR  = DEF_UART_STAT_ADDR
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_bridge_if.slave                cpu,
    output logic [SRAM_WORDS_LOG2-1:0] sram_addr,
    output logic [31:0]                sram_dout,
    input  logic [31:0]                sram_din,
    output logic                       sram_doe,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic [3:0]                 sram_be_n,
    input  logic                       uart_tx_idle,
    output logic                       uart_tx_start,
    output logic [7:0]                 uart_tx_data,
    input  logic                       uart_rx_avail,
    input  logic [7:0]                 uart_rx_data,
    output logic                       uart_rx_ack
);

    // Window size in bytes, one bit wider so the comparison cannot wrap
    localparam logic [32:0] SRAM_BYTES = 33'd4 << SRAM_WORDS_LOG2;

    bridgeState_e               state_r;
    logic [31:0]                rdata_r;
    logic [SRAM_WORDS_LOG2-1:0] sramAddr_r;
    logic [31:0]                sramDout_r;
    logic                       sramDoe_r;
    logic                       sramCeN_r;
    logic                       sramOeN_r;
    logic                       sramWeN_r;
    logic [3:0]                 sramBeN_r;
    logic                       txStart_r;
    logic [7:0]                 txData_r;
    logic                       rxAck_r;

    logic [31:0] sramOffset_s;
    logic        isSram_s;
    logic        isUartData_s;
    logic        isUartStat_s;
    logic [31:0] alignedLoad_s;

    // Address decode; unsigned subtraction makes addresses below the base wrap out of range
    assign sramOffset_s = cpu.mem_addr - SRAM_BASE;
    assign isSram_s     = ({1'b0, sramOffset_s} < SRAM_BYTES);
    assign isUartData_s = (cpu.mem_addr == UART_DATA_ADDR);
    assign isUartStat_s = (cpu.mem_addr == UART_STAT_ADDR);

    // The request is held stable while busy, so the live address still selects the lane in RD2
    mem_load_align u_align (
        .word    (sram_din),
        .addrLow (cpu.mem_addr[1:0]),
        .rsel    (cpu.mem_rsel),
        .result  (alignedLoad_s)
    );

    // Transaction FSM; every strobe is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rdata_r    <= 32'd0;
            sramAddr_r <= '0;
            sramDout_r <= 32'd0;
            sramDoe_r  <= 1'b0;
            sramCeN_r  <= 1'b1;
            sramOeN_r  <= 1'b1;
            sramWeN_r  <= 1'b1;
            sramBeN_r  <= 4'b1111;
            txStart_r  <= 1'b0;
            txData_r   <= 8'd0;
            rxAck_r    <= 1'b0;
        end else begin
            // UART strobes are single-cycle pulses unless re-armed below
            txStart_r <= 1'b0;
            rxAck_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cpu.mem_we) begin
                        if (isSram_s) begin
                            sramAddr_r <= sramOffset_s[SRAM_WORDS_LOG2+1:2];
                            sramDout_r <= storeData(cpu.mem_wsel, cpu.mem_wdata);
                            sramBeN_r  <= storeByteEnN(cpu.mem_wsel, cpu.mem_addr[1:0]);
                            sramCeN_r  <= 1'b0;
                            sramWeN_r  <= 1'b0;
                            sramDoe_r  <= 1'b1;
                            state_r    <= ST_WR1;
                        end else if (isUartData_s) begin
                            txData_r <= cpu.mem_wdata[7:0];
                            if (uart_tx_idle) begin
                                txStart_r <= 1'b1;
                                state_r   <= ST_DONE;
                            end else begin
                                state_r <= ST_UWAIT;
                            end
                        end else begin
                            // Status-register and unmapped stores are dropped
                            state_r <= ST_DONE;
                        end
                    end else if (cpu.mem_re) begin
                        if (isSram_s) begin
                            sramAddr_r <= sramOffset_s[SRAM_WORDS_LOG2+1:2];
                            sramBeN_r  <= 4'b0000;
                            sramCeN_r  <= 1'b0;
                            sramOeN_r  <= 1'b0;
                            state_r    <= ST_RD1;
                        end else if (isUartStat_s) begin
                            rdata_r <= {30'd0, uart_rx_avail, uart_tx_idle};
                            state_r <= ST_DONE;
                        end else if (isUartData_s) begin
                            // Byte is captured this edge, so consuming it now is safe
                            rdata_r <= {24'd0, uart_rx_data};
                            rxAck_r <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            rdata_r <= 32'd0;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD1: begin
                    state_r <= ST_RD2;
                end
                ST_RD2: begin
                    rdata_r   <= alignedLoad_s;
                    sramCeN_r <= 1'b1;
                    sramOeN_r <= 1'b1;
                    sramBeN_r <= 4'b1111;
                    state_r   <= ST_DONE;
                end
                ST_WR1: begin
                    // Write pulse ends; data and chip enable stay for hold time
                    sramWeN_r <= 1'b1;
                    state_r   <= ST_WR2;
                end
                ST_WR2: begin
                    sramCeN_r <= 1'b1;
                    sramDoe_r <= 1'b0;
                    sramBeN_r <= 4'b1111;
                    state_r   <= ST_DONE;
                end
                ST_UWAIT: begin
                    if (uart_tx_idle) begin
                        txStart_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r <= ST_UWAIT;
                    end
                end
                ST_DONE: begin
                    // The pipeline advances at the end of this cycle; the old request is ignored
                    state_r <= ST_IDLE;
                end
                default: begin
                    sramDoe_r <= 1'b0;
                    sramCeN_r <= 1'b1;
                    sramOeN_r <= 1'b1;
                    sramWeN_r <= 1'b1;
                    sramBeN_r <= 4'b1111;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu.mem_rdata = rdata_r;
    assign cpu.done      = (state_r == ST_DONE);
    assign cpu.busy      = (cpu.mem_re | cpu.mem_we) & (state_r != ST_DONE);

    assign sram_addr     = sramAddr_r;
    assign sram_dout     = sramDout_r;
    assign sram_doe      = sramDoe_r;
    assign sram_ce_n     = sramCeN_r;
    assign sram_oe_n     = sramOeN_r;
    assign sram_we_n     = sramWeN_r;
    assign sram_be_n     = sramBeN_r;
    assign uart_tx_start = txStart_r;
    assign uart_tx_data  = txData_r;
    assign uart_rx_ack   = rxAck_r;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge
// Directed self-checking bench for mem_bridge with a small SRAM model,
// strobe monitors and a queue of expected load results.
module tb_mem_bridge;
    import mem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] sramAddr;
    logic [31:0] sramDout;
    logic [31:0] sramDin;
    logic        sramDoe;
    logic        ceN;
    logic        oeN;
    logic        weN;
    logic [3:0]  beN;
    logic        txIdle;
    logic        txStart;
    logic [7:0]  txData;
    logic        rxAvail;
    logic [7:0]  rxData;
    logic        rxAck;

    int errors = 0;
    int checks = 0;

    logic [31:0] expQ[$];
    logic [31:0] sramMem [0:63];

    // Strobe monitor state, written only by the monitor process
    int          weLowCnt = 0;
    int          txCnt = 0;
    int          ackCnt = 0;
    logic [31:0] lastWeAddr = 32'd0;
    logic [31:0] lastWeDout = 32'd0;
    logic [3:0]  lastWeBe = 4'hF;
    logic [7:0]  lastTxData = 8'd0;

    always #5 clk = ~clk;

    mem_bridge_if cpuBus();

    mem_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .cpu           (cpuBus),
        .sram_addr     (sramAddr),
        .sram_dout     (sramDout),
        .sram_din      (sramDin),
        .sram_doe      (sramDoe),
        .sram_ce_n     (ceN),
        .sram_oe_n     (oeN),
        .sram_we_n     (weN),
        .sram_be_n     (beN),
        .uart_tx_idle  (txIdle),
        .uart_tx_start (txStart),
        .uart_tx_data  (txData),
        .uart_rx_avail (rxAvail),
        .uart_rx_data  (rxData),
        .uart_rx_ack   (rxAck)
    );

    // Asynchronous SRAM model: read when selected and output-enabled, write lanes while we_n low
    assign sramDin = (!ceN && !oeN) ? sramMem[sramAddr[5:0]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!ceN && !weN) begin
            for (int b = 0; b < 4; b++) begin
                if (!beN[b]) sramMem[sramAddr[5:0]][8*b +: 8] <= sramDout[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (!weN) begin
            weLowCnt   = weLowCnt + 1;
            lastWeAddr = {11'd0, sramAddr};
            lastWeDout = sramDout;
            lastWeBe   = beN;
        end
        if (txStart) begin
            txCnt      = txCnt + 1;
            lastTxData = txData;
        end
        if (rxAck) ackCnt = ackCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge, wait (bounded) for done, check latency, busy and load data
    task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic re, input logic we, input logic [1:0] rsel,
                          input logic wsel, input int expLat, input int riseAt);
        int lat = 0;
        int busyCnt = 0;
        logic [31:0] expVal;
        cpuBus.mem_addr  = addr;
        cpuBus.mem_wdata = wdata;
        cpuBus.mem_re    = re;
        cpuBus.mem_we    = we;
        cpuBus.mem_rsel  = rsel;
        cpuBus.mem_wsel  = wsel;
        #1;
        if (cpuBus.busy) busyCnt++;
        while (!cpuBus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!cpuBus.done && cpuBus.busy) busyCnt++;
            if (riseAt != 0 && lat == riseAt) txIdle = 1'b1;
        end
        check({tag, " latency"}, lat, expLat);
        check({tag, " busy cycles"}, busyCnt, expLat);
        check({tag, " busy in done"}, {31'd0, cpuBus.busy}, 32'd0);
        if (re && !we) begin
            expVal = (expQ.size() != 0) ? expQ.pop_front() : 32'hBAD0_BAD0;
            check({tag, " rdata"}, cpuBus.mem_rdata, expVal);
        end
        cpuBus.mem_re = 1'b0;
        cpuBus.mem_we = 1'b0;
        @(negedge clk);
        check({tag, " done pulse width"}, {31'd0, cpuBus.done}, 32'd0);
    endtask

    initial begin
        int weBase;
        int txBase;
        int ackBase;

        rst              = 1'b1;
        cpuBus.mem_addr  = 32'd0;
        cpuBus.mem_wdata = 32'd0;
        cpuBus.mem_re    = 1'b0;
        cpuBus.mem_we    = 1'b0;
        cpuBus.mem_rsel  = RSEL_WORD;
        cpuBus.mem_wsel  = WSEL_WORD;
        txIdle           = 1'b1;
        rxAvail          = 1'b0;
        rxData           = 8'd0;
        repeat (3) @(negedge clk);

        check("reset rdata", cpuBus.mem_rdata, 32'd0);
        check("reset done", {31'd0, cpuBus.done}, 32'd0);
        check("reset strobes", {27'd0, sramDoe, ceN, oeN, weN, txStart}, {27'd0, 5'b01110});
        check("reset be_n", {28'd0, beN}, 32'h0000_000F);
        check("reset rx_ack", {31'd0, rxAck}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word store then signed-byte load from the same word
        weBase = weLowCnt;
        access("sw 0x80000010", 32'h8000_0010, 32'h1234_5678, 1'b0, 1'b1, RSEL_WORD, WSEL_WORD, 3, 0);
        check("sw we_n low cycles", weLowCnt - weBase, 32'd1);
        check("sw sram_addr", lastWeAddr, 32'd4);
        check("sw dout", lastWeDout, 32'h1234_5678);
        check("sw be_n", {28'd0, lastWeBe}, 32'h0);
        expQ.push_back(32'h0000_0056);
        access("lb 0x80000011", 32'h8000_0011, 32'd0, 1'b1, 1'b0, RSEL_SBYTE, WSEL_WORD, 3, 0);

        // Halfword and byte extension
        access("sw 0x80000000", 32'h8000_0000, 32'h0000_F080, 1'b0, 1'b1, RSEL_WORD, WSEL_WORD, 3, 0);
        expQ.push_back(32'hFFFF_F080);
        access("lh 0x80000000", 32'h8000_0000, 32'd0, 1'b1, 1'b0, RSEL_SHALF, WSEL_WORD, 3, 0);
        expQ.push_back(32'h0000_0080);
        access("lbu 0x80000000", 32'h8000_0000, 32'd0, 1'b1, 1'b0, RSEL_UBYTE, WSEL_WORD, 3, 0);
        expQ.push_back(32'hFFFF_FF80);
        access("lb 0x80000000", 32'h8000_0000, 32'd0, 1'b1, 1'b0, RSEL_SBYTE, WSEL_WORD, 3, 0);

        // Byte store to the top lane; upper wdata bits must be ignored
        access("sb 0x80000003", 32'h8000_0003, 32'hFFFF_FFAB, 1'b0, 1'b1, RSEL_WORD, WSEL_BYTE, 3, 0);
        check("sb be_n", {28'd0, lastWeBe}, 32'h0000_0007);
        check("sb dout", lastWeDout, 32'hABAB_ABAB);
        check("rdata held over store", cpuBus.mem_rdata, 32'hFFFF_FF80);
        expQ.push_back(32'hAB00_F080);
        access("lw 0x80000000", 32'h8000_0000, 32'd0, 1'b1, 1'b0, RSEL_WORD, WSEL_WORD, 3, 0);

        // Unmapped load clears the previous load value
        expQ.push_back(32'd0);
        access("lw unmapped", 32'h0000_1000, 32'd0, 1'b1, 1'b0, RSEL_WORD, WSEL_WORD, 1, 0);

        // Both enables high: the store wins
        access("we+re 0x80000004", 32'h8000_0004, 32'h1122_3344, 1'b1, 1'b1, RSEL_WORD, WSEL_WORD, 3, 0);
        expQ.push_back(32'h1122_3344);
        access("lw 0x80000004", 32'h8000_0004, 32'd0, 1'b1, 1'b0, RSEL_WORD, WSEL_WORD, 3, 0);

        // UART transmit with tx_idle low for five cycles
        txIdle = 1'b0;
        txBase = txCnt;
        access("uart tx wait", DEF_UART_DATA_ADDR, 32'h1234_565A, 1'b0, 1'b1, RSEL_WORD, WSEL_WORD, 6, 5);
        check("uart tx pulses", txCnt - txBase, 32'd1);
        check("uart tx data", {24'd0, lastTxData}, 32'h0000_005A);

        // UART transmit with transmitter ready
        txBase = txCnt;
        access("uart tx ready", DEF_UART_DATA_ADDR, 32'h0000_00C7, 1'b0, 1'b1, RSEL_WORD, WSEL_WORD, 1, 0);
        check("uart tx ready pulses", txCnt - txBase, 32'd1);
        check("uart tx ready data", {24'd0, lastTxData}, 32'h0000_00C7);

        // UART status and data loads
        rxAvail = 1'b1;
        txIdle  = 1'b0;
        expQ.push_back(32'h0000_0002);
        access("uart status", DEF_UART_STAT_ADDR, 32'd0, 1'b1, 1'b0, RSEL_WORD, WSEL_WORD, 1, 0);
        txIdle  = 1'b1;
        rxData  = 8'hC3;
        ackBase = ackCnt;
        expQ.push_back(32'h0000_00C3);
        access("uart rx", DEF_UART_DATA_ADDR, 32'd0, 1'b1, 1'b0, RSEL_UBYTE, WSEL_WORD, 1, 0);
        check("uart rx_ack pulses", ackCnt - ackBase, 32'd1);
        rxAvail = 1'b0;

        // Reset during WR1 aborts the store
        weBase = weLowCnt;
        cpuBus.mem_addr  = 32'h8000_0020;
        cpuBus.mem_wdata = 32'hCAFE_F00D;
        cpuBus.mem_wsel  = WSEL_WORD;
        cpuBus.mem_we    = 1'b1;
        @(negedge clk);
        check("wr1 we_n", {31'd0, weN}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort strobes", {28'd0, ceN, oeN, weN, sramDoe}, 32'h0000_000E);
        check("abort be_n", {28'd0, beN}, 32'h0000_000F);
        check("abort done", {31'd0, cpuBus.done}, 32'd0);
        rst           = 1'b0;
        cpuBus.mem_we = 1'b0;
        @(negedge clk);
        expQ.push_back(32'd0);
        access("lw unmapped after reset", 32'h0000_1000, 32'd0, 1'b1, 1'b0, RSEL_WORD, WSEL_WORD, 1, 0);
        check("abort we_n low cycles", weLowCnt - weBase, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
